// File: rtl/riscv_mem_pkg.sv
// Shared constants for the RV32I data-memory stage: funct3 codes, MMIO offsets
// and the alignment helper used by the store/load decode.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] OFF_LED   = 4'h0;
  localparam logic [3:0] OFF_CYCLE = 4'h4;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_1000;

  // Access size lives in funct3[1:0] for both loads and stores.
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = |lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load-path lane select: picks the byte/halfword addressed by offset out of a
// 32-bit word and sign- or zero-extends it according to funct3.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   value = {24'b0, byte_sel};
      F3_H:    value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   value = {16'b0, half_sel};
      F3_W:    value = word;
      default: value = 32'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-side memory stage: byte-lane RAM with combinational read, sticky access
// error, and an optional I/O window (LED + cycle counter) built when MMIO_EN is defined.
module data_mem_unit
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        AccessErr,
  output logic [7:0]  Leds
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [AW-1:0] word_idx;
  logic          in_mmio;
  logic          code_bad;
  logic          align_bad;
  logic          access_bad;
  logic          ram_we;
  logic [3:0]    lane_en;
  logic [31:0]   wr_lanes;
  logic [31:0]   ram_word;
  logic [31:0]   mmio_word;
  logic [31:0]   word_src;
  logic [31:0]   ext_value;
  logic          err_reg;
  logic          err_next;

  assign word_idx  = Addr[AW+1:2];
  assign in_mmio   = (Addr[31:4] == MMIO_BASE[31:4]);
  assign align_bad = misaligned(Funct3, Addr[1:0]);

  always_comb begin
    if (MemWrite)
      code_bad = !(Funct3 inside {F3_B, F3_H, F3_W});
    else
      code_bad = !(Funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

`ifdef MMIO_EN
  assign access_bad = code_bad || align_bad || (in_mmio && (Funct3 != F3_W));
`else
  // With no I/O built, the window is a silent hole: no decode errors there.
  assign access_bad = !in_mmio && (code_bad || align_bad);
`endif

  assign ram_we = MemWrite && !access_bad && !in_mmio;

  always_comb begin
    lane_en  = 4'b0000;
    wr_lanes = WriteData;
    case (size_e'(Funct3[1:0]))
      SIZE_B: begin
        lane_en  = 4'b0001 << Addr[1:0];
        wr_lanes = {4{WriteData[7:0]}};
      end
      SIZE_H: begin
        lane_en  = Addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{WriteData[15:0]}};
      end
      SIZE_W:  lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
    if (!ram_we)
      lane_en = 4'b0000;
  end

  // One byte-wide array per lane so unselected lanes are never rewritten;
  // a store coinciding with reset is dropped.
  logic [7:0] rd_lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (lane_en[gi] && !reset)
        mem[word_idx] <= wr_lanes[8*gi +: 8];
    end

    assign rd_lane[gi] = mem[word_idx];
  end

  assign ram_word = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};

`ifdef MMIO_EN
  logic [7:0]  leds_reg;
  logic [7:0]  leds_next;
  logic [31:0] cycle_reg;
  logic [31:0] cycle_next;
  logic        mmio_we;

  assign mmio_we = MemWrite && in_mmio && !access_bad;

  always_comb begin
    leds_next  = leds_reg;
    cycle_next = cycle_reg + 32'd1;
    if (mmio_we && (Addr[3:0] == OFF_LED))
      leds_next = WriteData[7:0];
    if (mmio_we && (Addr[3:0] == OFF_CYCLE))
      cycle_next = WriteData;
    case (Addr[3:0])
      OFF_LED:   mmio_word = {24'b0, leds_reg};
      OFF_CYCLE: mmio_word = cycle_reg;
      default:   mmio_word = 32'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_reg  <= 8'h00;
      cycle_reg <= 32'h0;
    end else begin
      leds_reg  <= leds_next;
      cycle_reg <= cycle_next;
    end
  end

  assign Leds = leds_reg;
`else
  assign mmio_word = 32'b0;
  assign Leds      = 8'h00;
`endif

  assign err_next = err_reg || ((MemRead || MemWrite) && access_bad);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_reg <= 1'b0;
    else
      err_reg <= err_next;
  end

  assign AccessErr = err_reg;
  assign word_src  = in_mmio ? mmio_word : ram_word;

  load_extend u_load_extend (
    .word   (word_src),
    .offset (Addr[1:0]),
    .funct3 (Funct3),
    .value  (ext_value)
  );

  assign ReadData = access_bad ? 32'b0 : ext_value;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit; MMIO checks follow the MMIO_EN build option.
module tb_data_mem_unit;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        AccessErr;
  logic [7:0]  Leds;

  int errors = 0;
  int checks = 0;

  data_mem_unit #(.DEPTH_WORDS(64), .MMIO_BASE(32'h0000_1000)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Funct3    (Funct3),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .AccessErr (AccessErr),
    .Leds      (Leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    MemWrite  = we;
    MemRead   = re;
    Funct3    = f3;
    Addr      = a;
    WriteData = wd;
    #1;
    $display("txn we=%0b re=%0b f3=%0d addr=%h wd=%h rd=%h err=%0b leds=%h",
             we, re, f3, a, wd, ReadData, AccessErr, Leds);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checks++; if (AccessErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", AccessErr); end
    checks++; if (Leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h want 00", Leds); end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 32'h1004, 32'h0);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_cycle0: got %h want 00000000", ReadData); end
    tick();
`ifdef MMIO_EN
    checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL reset_cycle1: got %h want 00000001", ReadData); end
`else
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL nommio_cycle: got %h want 00000000", ReadData); end
`endif
  endtask

  task automatic test_loads();
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h8765_4321);
    tick();
    drive(1'b0, 1'b1, 3'b000, 32'h13, 32'h0);
    checks++; if (ReadData !== 32'hFFFF_FF87) begin errors++; $display("FAIL lb_13: got %h want ffffff87", ReadData); end
    drive(1'b0, 1'b1, 3'b100, 32'h13, 32'h0);
    checks++; if (ReadData !== 32'h0000_0087) begin errors++; $display("FAIL lbu_13: got %h want 00000087", ReadData); end
    drive(1'b0, 1'b1, 3'b001, 32'h12, 32'h0);
    checks++; if (ReadData !== 32'hFFFF_8765) begin errors++; $display("FAIL lh_12: got %h want ffff8765", ReadData); end
    drive(1'b0, 1'b1, 3'b101, 32'h10, 32'h0);
    checks++; if (ReadData !== 32'h0000_4321) begin errors++; $display("FAIL lhu_10: got %h want 00004321", ReadData); end
    drive(1'b0, 1'b1, 3'b001, 32'h10, 32'h0);
    checks++; if (ReadData !== 32'h0000_4321) begin errors++; $display("FAIL lh_10: got %h want 00004321", ReadData); end
    drive(1'b0, 1'b1, 3'b000, 32'h11, 32'h0);
    checks++; if (ReadData !== 32'h0000_0043) begin errors++; $display("FAIL lb_11: got %h want 00000043", ReadData); end
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    checks++; if (ReadData !== 32'h8765_4321) begin errors++; $display("FAIL lw_10: got %h want 87654321", ReadData); end
    tick();
  endtask

  task automatic test_lanes();
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 1'b0, 3'b000, 32'h21, 32'hABCD_EF00);
    tick();
    drive(1'b1, 1'b0, 3'b001, 32'h22, 32'h5566_1234);
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
    checks++; if (ReadData !== 32'h1234_00FF) begin errors++; $display("FAIL lanes_lw_20: got %h want 123400ff", ReadData); end
    checks++; if (AccessErr !== 1'b0) begin errors++; $display("FAIL lanes_err: got %b want 0", AccessErr); end
  endtask

  task automatic test_unsupported();
    drive(1'b0, 1'b0, 3'b010, 32'h22, 32'h0);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL idle_bad_rd: got %h want 00000000", ReadData); end
    tick();
    checks++; if (AccessErr !== 1'b0) begin errors++; $display("FAIL idle_no_err: got %b want 0", AccessErr); end
    drive(1'b0, 1'b1, 3'b011, 32'h10, 32'h0);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL f3_011_rd: got %h want 00000000", ReadData); end
    tick();
    checks++; if (AccessErr !== 1'b1) begin errors++; $display("FAIL f3_011_err: got %b want 1", AccessErr); end
    drive(1'b1, 1'b0, 3'b100, 32'h20, 32'h0);
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
    checks++; if (ReadData !== 32'h1234_00FF) begin errors++; $display("FAIL sbu_suppressed: got %h want 123400ff", ReadData); end
    pulse_reset();
    checks++; if (AccessErr !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", AccessErr); end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 3'b001, 32'h21, 32'h0000_BEEF);
    checks++; if (AccessErr !== 1'b0) begin errors++; $display("FAIL mis_err_before_edge: got %b want 0", AccessErr); end
    tick();
    checks++; if (AccessErr !== 1'b1) begin errors++; $display("FAIL mis_err_set: got %b want 1", AccessErr); end
    drive(1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
    checks++; if (ReadData !== 32'h1234_00FF) begin errors++; $display("FAIL mis_store_dropped: got %h want 123400ff", ReadData); end
    drive(1'b0, 1'b1, 3'b010, 32'h22, 32'h0);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL lw_22_zero: got %h want 00000000", ReadData); end
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    checks++; if (AccessErr !== 1'b1) begin errors++; $display("FAIL mis_err_sticky: got %b want 1", AccessErr); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
    checks++; if (ReadData !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_word0: got %h want cafef00d", ReadData); end
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    checks++; if (ReadData !== 32'h8765_4321) begin errors++; $display("FAIL wrap_word4: got %h want 87654321", ReadData); end
  endtask

  task automatic test_mmio();
    pulse_reset();
`ifdef MMIO_EN
    drive(1'b1, 1'b0, 3'b010, 32'h1004, 32'hFFFF_FFFE);
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h1004, 32'h0);
    checks++; if (ReadData !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cyc_loaded: got %h want fffffffe", ReadData); end
    tick();
    checks++; if (ReadData !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_inc1: got %h want ffffffff", ReadData); end
    tick();
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL cyc_wrap: got %h want 00000000", ReadData); end
    tick();
    checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL cyc_after_wrap: got %h want 00000001", ReadData); end
    drive(1'b1, 1'b0, 3'b010, 32'h1000, 32'h1234_56A5);
    tick();
    checks++; if (Leds !== 8'hA5) begin errors++; $display("FAIL leds_sw: got %h want a5", Leds); end
    drive(1'b0, 1'b1, 3'b010, 32'h1000, 32'h0);
    checks++; if (ReadData !== 32'h0000_00A5) begin errors++; $display("FAIL leds_lw: got %h want 000000a5", ReadData); end
    drive(1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
    checks++; if (ReadData !== 32'hCAFE_F00D) begin errors++; $display("FAIL led_no_ram_alias: got %h want cafef00d", ReadData); end
    drive(1'b1, 1'b0, 3'b010, 32'h100C, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h100C, 32'h0);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL mmio_hole_rd: got %h want 00000000", ReadData); end
    tick();
    checks++; if (AccessErr !== 1'b0) begin errors++; $display("FAIL mmio_hole_err: got %b want 0", AccessErr); end
    drive(1'b1, 1'b0, 3'b000, 32'h1000, 32'h0000_003C);
    tick();
    checks++; if (AccessErr !== 1'b1) begin errors++; $display("FAIL mmio_sb_err: got %b want 1", AccessErr); end
    checks++; if (Leds !== 8'hA5) begin errors++; $display("FAIL mmio_sb_leds: got %h want a5", Leds); end
`else
    drive(1'b1, 1'b0, 3'b010, 32'h1000, 32'h1234_56A5);
    tick();
    checks++; if (Leds !== 8'h00) begin errors++; $display("FAIL nommio_leds: got %h want 00", Leds); end
    drive(1'b0, 1'b1, 3'b010, 32'h1000, 32'h0);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL nommio_rd: got %h want 00000000", ReadData); end
    drive(1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
    checks++; if (ReadData !== 32'hCAFE_F00D) begin errors++; $display("FAIL nommio_no_ram_alias: got %h want cafef00d", ReadData); end
    drive(1'b1, 1'b0, 3'b000, 32'h1001, 32'h0000_003C);
    tick();
    checks++; if (AccessErr !== 1'b0) begin errors++; $display("FAIL nommio_no_err: got %b want 0", AccessErr); end
`endif
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 3'b001, 32'h21, 32'h0000_BEEF);
    tick();
    checks++; if (AccessErr !== 1'b1) begin errors++; $display("FAIL pre_reset_err: got %b want 1", AccessErr); end
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h1111_1111);
    reset = 1'b1;
    #1;
    checks++; if (AccessErr !== 1'b0) begin errors++; $display("FAIL async_err: got %b want 0", AccessErr); end
    checks++; if (Leds !== 8'h00) begin errors++; $display("FAIL async_leds: got %h want 00", Leds); end
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h1004, 32'h0);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL async_cycle: got %h want 00000000", ReadData); end
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    checks++; if (ReadData !== 32'h8765_4321) begin errors++; $display("FAIL reset_store_dropped: got %h want 87654321", ReadData); end
    reset = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 32'h1004, 32'h0);
    tick();
`ifdef MMIO_EN
    checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL first_edge_cycle: got %h want 00000001", ReadData); end
`else
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL first_edge_nommio: got %h want 00000000", ReadData); end
`endif
  endtask

  initial begin
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Funct3    = 3'b010;
    Addr      = 32'h0;
    WriteData = 32'h0;
    reset     = 1'b1;
    test_reset();
    test_loads();
    test_lanes();
    test_unsupported();
    test_misaligned();
    test_wrap();
    test_mmio();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
